vga_line_prefetcher: RTL
========================

# vga_line_prefetcher

Parametrised successor to the VGA data controller. It prefetches framebuffer words from SRAM into a DEPTH-entry FIFO under a read/busy/data_en handshake, and unpacks each word into BPP-bit pixels, one per clock, during the active horizontal state. It sits between the SRAM arbiter and the VGA timing generator. It adds configurable pixel depth, per-line fetch limiting, frame-start rewind and underrun detection.

## Interface
- BPP, 2, bits per pixel; legal values 1, 2, 4, 8.
- DEPTH, 8, FIFO depth in 32-bit words; power of two, minimum 2.
- H_ACTIVE, 640, active pixels per line; H_ACTIVE*BPP must be a multiple of 32.
- FB_BASE, 0, word address of pixel (0,0).
- WORDS_PER_LINE, derived, equals H_ACTIVE*BPP/32 (40 at the defaults).
- Clock and reset (already decided): one clock `clk`; reset `nrst` is asynchronous and active-low.
- clk  in  1  system clock, 25 MHz.
- nrst  in  1  asynchronous active-low reset.
- VGA_state  in  2  horizontal state: 0 sync, 1 back porch, 2 active, 3 front porch.
- v_active  in  1  current line is inside the vertical active region.
- frame_start  in  1  one-cycle pulse at vsync start.
- SRAM_busy  in  1  arbiter stall; the read is not served while high.
- data_en  in  1  data_from_SRAM is valid for the outstanding read.
- data_from_SRAM  in  32  read data.
- read  out  1  read request.
- SRAM_address  out  32  word address of the current request.
- byte_select_out  out  4  4'b1111 while read is high, else 4'b0000.
- pixel  out  BPP  current pixel value.
- pixel_valid  out  1  pixel came from fetched data.
- underrun  out  1  sticky underrun flag.
- fifo_level  out  $clog2(DEPTH)+1  number of occupied FIFO entries.

## Operation
- **Fetch FSM, states IDLE and FETCH.**
  - IDLE goes to FETCH when all of the following hold: v_active=1, line_words < WORDS_PER_LINE, fifo_level < DEPTH.
  - In FETCH: read=1 and SRAM_address is held stable.
  - A capture happens on a clk edge where data_en=1 and SRAM_busy=0. On a capture: the word is pushed into the FIFO, the address increments by 1, line_words increments, and the FSM returns to IDLE.
  - At most one read is outstanding at a time.
- **Line accounting.**
  - line_words clears when VGA_state changes from 2 to any other value.
  - Once line_words reaches WORDS_PER_LINE, no further reads occur until that clear.
  - The address does not rewind at line end; it continues linearly.
- **Unpack.**
  - On each cycle with VGA_state==2 and v_active=1, pixel index k advances by 1, wrapping at 32/BPP.
  - The emitted pixel is head[31-k*BPP -: BPP], i.e. MSB first.
  - At the last k of a word the FIFO pops, if it is non-empty.
  - k clears to 0 when VGA_state leaves 2.
- **Underrun.** If the FIFO is empty when a pixel is needed:
  - pixel=0 and pixel_valid=0;
  - underrun sets;
  - k still advances and no pop occurs.
- **Outside active (VGA_state!=2 or v_active=0).** pixel=0, pixel_valid=0, no pop.
- **frame_start.**
  - Flushes the FIFO, clears line_words, k and underrun.
  - Loads the address with FB_BASE and forces the FSM to IDLE.
  - It takes priority over a simultaneous capture; that data is discarded.
- **Simultaneous push and pop.** fifo_level is unchanged. A push into a full FIFO cannot occur, because the IDLE guard prevents it.
- **Address width.** The address increments modulo 2^32.

## Timing
- **Reset values.** read=0, SRAM_address=FB_BASE, byte_select_out=0, pixel=0, pixel_valid=0, underrun=0, fifo_level=0, FSM=IDLE.
- **Reset mid-operation.** Asserting nrst mid-operation forces these values immediately, asynchronously, and any in-flight data is dropped.
- **Read request.** read rises on the clk edge after the IDLE guard becomes true.
- **Capture.** A capture edge updates fifo_level and drops read on that same edge. The next read rises one edge later at the earliest, so back-to-back words take 2 cycles minimum.
- **Stall.** SRAM_busy=1 holds read and the address for any number of cycles.
- **Pixel outputs.** pixel and pixel_valid are registered: a pixel reflects the VGA_state sampled on the previous edge (1-cycle latency).
- **Pop.** The pop after the last pixel of a word makes the next word visible for the following pixel, with no bubble.
- **underrun and frame_start.** underrun sets on the edge of the failing pixel and clears on the frame_start edge.

## Test plan
- **Reset.** Assert nrst low during FETCH → all outputs take their reset values at once; read=0 and SRAM_address=FB_BASE(0).
- **Prefill.** v_active=1, VGA_state=0, data_en=1, busy=0 → addresses 0..7 captured every 2 cycles; read stays 0 once fifo_level=8.
- **Unpack, BPP=2.** Head word 32'h6AAA5556 with 16 active cycles → pixels 1,2,2,2,2,2,2,2,1,1,1,1,1,1,1,2, pixel_valid=1 throughout, then a pop (fifo_level drops by 1).
- **Stall.** SRAM_busy=1 for 5 cycles during FETCH → read=1 and the address held constant, no push; capture on the 6th edge.
- **Underrun.** data_en=0 for a whole active line → pixel=0, pixel_valid=0, underrun=1; underrun persists past the line end and clears on frame_start.
- **Line limit and rewind.** Full line at the defaults → exactly 40 captures (addresses 0..39), then read=0 until VGA_state leaves 2; the next line starts at address 40. A frame_start pulse mid-FETCH → fifo_level=0, the next request goes to address 0, and the concurrent data_en word is not stored.

Source files
------------

// File: rtl/vga_line_prefetcher.sv
// Prefetches framebuffer words from SRAM into a small FIFO and unpacks them
// MSB-first into BPP-bit pixels during the active part of each visible line.
module vga_line_prefetcher #(
  parameter int          BPP      = 2,
  parameter int          DEPTH    = 8,
  parameter int          H_ACTIVE = 640,
  parameter logic [31:0] FB_BASE  = 32'd0
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [1:0]               VGA_state,
  input  logic                     v_active,
  input  logic                     frame_start,
  input  logic                     SRAM_busy,
  input  logic                     data_en,
  input  logic [31:0]              data_from_SRAM,
  output logic                     read,
  output logic [31:0]              SRAM_address,
  output logic [3:0]               byte_select_out,
  output logic [BPP-1:0]           pixel,
  output logic                     pixel_valid,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int WPL = H_ACTIVE * BPP / 32;
  localparam int PPW = 32 / BPP;
  localparam int KW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(WPL + 1);

  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, state_nx;

  logic [DEPTH-1:0][31:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic [LW-1:0]          line_words;
  logic [KW-1:0]          k;
  logic [1:0]             vs_q;
  logic [4:0]             shamt;
  logic                   capture, active, empty, push, pop, line_end, guard, last_k;

  assign capture  = (state == FETCH) && data_en && !SRAM_busy;
  assign active   = (VGA_state == 2'd2) && v_active;
  assign empty    = (count == '0);
  assign last_k   = (k == KW'(PPW - 1));
  // frame_start discards whatever the same edge would have pushed or popped
  assign push     = capture && !frame_start;
  assign pop      = active && !empty && last_k && !frame_start;
  assign line_end = (vs_q == 2'd2) && (VGA_state != 2'd2);
  assign guard    = v_active && (line_words < LW'(WPL)) && (count < (AW+1)'(DEPTH));
  assign shamt    = 5'((PPW - 1 - int'(k)) * BPP);

  assign read            = (state == FETCH);
  assign byte_select_out = {4{read}};
  assign fifo_level      = count;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (guard)   state_nx = FETCH;
      FETCH:   if (capture) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (frame_start) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_from_SRAM;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      line_words   <= '0;
      k            <= '0;
      vs_q         <= 2'd0;
      SRAM_address <= FB_BASE;
      pixel        <= '0;
      pixel_valid  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      vs_q <= VGA_state;
      if (frame_start) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        line_words   <= '0;
        k            <= '0;
        SRAM_address <= FB_BASE;
        pixel        <= '0;
        pixel_valid  <= 1'b0;
        underrun     <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr       <= wr_ptr + 1'b1;
          SRAM_address <= SRAM_address + 32'd1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        line_words <= (line_end ? '0 : line_words) + LW'(push);

        if (active) begin
          k <= last_k ? '0 : k + 1'b1;
          if (!empty) begin
            pixel       <= BPP'(mem[rd_ptr] >> shamt);
            pixel_valid <= 1'b1;
          end else begin
            pixel       <= '0;
            pixel_valid <= 1'b0;
            underrun    <= 1'b1;
          end
        end else begin
          if (VGA_state != 2'd2) k <= '0;
          pixel       <= '0;
          pixel_valid <= 1'b0;
        end
      end
    end
  end
endmodule
